// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Purpose:
//   Word-organised data memory with a simple request/ready handshake for the
//   load/store unit. An access is accepted in IDLE, optionally stretched by
//   WAIT_CYCLES wait states, and completes with a single-cycle ready pulse in
//   RESP. Writes are byte-masked. Reads return the full 32-bit word.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of 2, 16..65536)
//   WAIT_CYCLES : extra wait states per access (0..7)
//
// Ports:
//   clk_i       in   1   clock, all state on the rising edge
//   rst_i       in   1   synchronous active-low reset
//   mem_req_i   in   1   access request, held by the LSU until ready
//   mem_we_i    in   1   1 = write, 0 = read
//   mem_be_i    in   4   byte enables, bit n selects bits [8n+7:8n]
//   mem_addr_i  in  32   byte address, word index = mem_addr_i[ADDR_W+1:2]
//   mem_wd_i    in  32   write data (lane-replicated by the LSU)
//   mem_rd_o    out 32   read data, non-zero only during the ready pulse
//   mem_err_o   out  1   (DMEM_ERR_EN only) out-of-range address in RESP
//   mem_ready_o out  1   one-cycle completion pulse
//
// Configuration:
//   DMEM_ERR_EN : when defined, address bits above the array are checked and
//                 an out-of-range access raises mem_err_o instead of touching
//                 the array. When undefined, those bits are ignored and the
//                 address space aliases onto the array.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
`ifdef DMEM_ERR_EN
    output logic        mem_err_o,
`endif
    output logic        mem_ready_o
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    // Value loaded into the wait counter on accept; the WAIT state is never
    // entered when WAIT_CYCLES is 0, so the load value is irrelevant there.
    localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                enter_resp;

    logic                we_q;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wd_q;
    logic [31:0]         rd_q;

    logic                acc_we;
    logic [3:0]          acc_be;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wd;
    logic                acc_err;

    logic [31:0]         mem [DEPTH_WORDS];

`ifdef DMEM_ERR_EN
    logic                err_q;
    logic                in_err;
    logic [1:0]          unused_addr_bits;

    assign in_err           = |mem_addr_i[31:ADDR_W+2];
    assign unused_addr_bits = mem_addr_i[1:0];
`else
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};
`endif

    // With zero wait states the array is touched on the same edge that
    // accepts the request, before the latches hold it, so in IDLE the access
    // fields come straight from the inputs and from the latches otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we  = mem_we_i;
            acc_be  = mem_be_i;
            acc_idx = mem_addr_i[ADDR_W+1:2];
            acc_wd  = mem_wd_i;
`ifdef DMEM_ERR_EN
            acc_err = in_err;
`else
            acc_err = 1'b0;
`endif
        end else begin
            acc_we  = we_q;
            acc_be  = be_q;
            acc_idx = idx_q;
            acc_wd  = wd_q;
`ifdef DMEM_ERR_EN
            acc_err = err_q;
`else
            acc_err = 1'b0;
`endif
        end
    end

    // Next-state logic. enter_resp marks the edge on which the array is
    // written or read; request inputs only matter while IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && mem_req_i) begin
                we_q  <= mem_we_i;
                be_q  <= mem_be_i;
                idx_q <= mem_addr_i[ADDR_W+1:2];
                wd_q  <= mem_wd_i;
`ifdef DMEM_ERR_EN
                err_q <= in_err;
`endif
            end
            // Read data lives only for the RESP cycle; any other edge clears it.
            rd_q <= (enter_resp && !acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
        end
    end

    // The array has no reset. Gating with rst_i keeps a reset that lands on
    // the final wait edge from committing the aborted write.
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready_o = (state_q == RESP);
    assign mem_rd_o    = rd_q;
`ifdef DMEM_ERR_EN
    assign mem_err_o   = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Self-checking bench for data_mem_ctrl (WAIT_CYCLES = 3, DEPTH_WORDS = 1024).
// A transaction-level model tracks when each accepted access must complete
// (accept cycle + 1 + WAIT_CYCLES) and what memory holds; a compare process
// checks ready/rd/err against it every cycle. Directed accesses with literal
// expectations come first, followed by randomized traffic including resets.
// Builds with or without DMEM_ERR_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int DEPTH = 1024;
    localparam int WC    = 3;
    localparam int AW    = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_be_i = 4'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_wd_i = 32'd0;
    logic [31:0] mem_rd_o;
    logic        mem_ready_o;
    logic        dut_err;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
    assign dut_err = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_be_i   (mem_be_i),
        .mem_addr_i (mem_addr_i),
        .mem_wd_i   (mem_wd_i),
        .mem_rd_o   (mem_rd_o),
`ifdef DMEM_ERR_EN
        .mem_err_o  (dut_err),
`endif
        .mem_ready_o(mem_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [DEPTH];
    longint      cyc = 0;
    longint      resp_cyc = -10;
    bit          busy = 1'b0;
    bit          model_live = 1'b0;
    bit          l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr;
    logic [31:0] l_wd;
    bit          exp_ready = 1'b0;
    logic [31:0] exp_rd = 32'd0;
    bit          exp_err = 1'b0;

    bit          c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr;
    logic [31:0] c_wd;
    bit          c_err;
    logic [AW-1:0] c_idx;
    bit          commit_now;

    always_comb begin
        c_we   = busy ? l_we   : mem_we_i;
        c_be   = busy ? l_be   : mem_be_i;
        c_addr = busy ? l_addr : mem_addr_i;
        c_wd   = busy ? l_wd   : mem_wd_i;
        c_idx  = c_addr[AW+1:2];
        c_err  = ERR_EN && (c_addr[31:AW+2] != '0);
        commit_now = rst_i && ((busy && (cyc == resp_cyc - 1)) ||
                               (!busy && mem_req_i && (WC == 0)));
    end

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_i) model_live <= 1'b1;
        exp_ready <= 1'b0;
        exp_rd    <= 32'd0;
        exp_err   <= 1'b0;
        if (!rst_i) begin
            busy <= 1'b0;
        end else if (busy && cyc == resp_cyc) begin
            busy <= 1'b0;
        end else if (!busy && mem_req_i) begin
            busy     <= 1'b1;
            resp_cyc <= cyc + 1 + WC;
            l_we     <= mem_we_i;
            l_be     <= mem_be_i;
            l_addr   <= mem_addr_i;
            l_wd     <= mem_wd_i;
        end
        if (commit_now) begin
            exp_ready <= 1'b1;
            exp_err   <= c_err;
            if (!c_err) begin
                if (c_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_be[b]) mmem[c_idx][8*b +: 8] <= c_wd[8*b +: 8];
                    end
                end else begin
                    exp_rd <= mmem[c_idx];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (model_live) begin
            checks++;
            if (mem_ready_o !== exp_ready || mem_rd_o !== exp_rd || dut_err !== exp_err) begin
                errors++;
                $display("[TB] FAIL cycle_compare cyc=%0d ready=%b exp=%b rd=%h exp=%h err=%b exp=%b",
                         cyc, mem_ready_o, exp_ready, mem_rd_o, exp_rd, dut_err, exp_err);
            end
        end
    end

    // ---------------- tasks ----------------
    task automatic applyStimulus(input bit r, input bit w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        mem_req_i  = r;
        mem_we_i   = w;
        mem_be_i   = b;
        mem_addr_i = a;
        mem_wd_i   = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Request must already be driven; waits (bounded) for the ready pulse.
    task automatic waitReady(input string name, output logic [31:0] rd, output bit e);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk_i);
            lat++;
            if (mem_ready_o) seen = 1'b1;
        end
        rd = mem_rd_o;
        e  = dut_err;
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput({name, "_latency"}, lat, 1 + WC);
    endtask

    task automatic doAccess(input string name, input bit w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output bit e);
        @(negedge clk_i);
        applyStimulus(1'b1, w, b, a, d);
        waitReady(name, rd, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        bit          e;
        int          pulses;
        int          pos;
        logic [31:0] a;

        $display("[TB] start, WAIT_CYCLES=%0d ERR_EN=%0d", WC, ERR_EN);
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk_i);
        checkOutput("reset_ready", {31'd0, mem_ready_o}, 32'd0);
        checkOutput("reset_rd", mem_rd_o, 32'd0);
        rst_i = 1'b1;

        doAccess("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r, e);
        checkOutput("wr10_rd_zero", r, 32'd0);
        doAccess("rd10", 1'b0, 4'hF, 32'h10, 32'd0, r, e);
        checkOutput("rd10_data", r, 32'hDEADBEEF);

        doAccess("bytewr12", 1'b1, 4'b0100, 32'h12, 32'h55555555, r, e);
        doAccess("rd_byte", 1'b0, 4'hF, 32'h10, 32'd0, r, e);
        checkOutput("rd_byte_data", r, 32'hDE55BEEF);
        checkOutput("model_word4", mmem[4], 32'hDE55BEEF);

        doAccess("be0_wr", 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, r, e);
        doAccess("rd_be0", 1'b0, 4'hF, 32'h10, 32'd0, r, e);
        checkOutput("rd_be0_data", r, 32'hDE55BEEF);

        // Read held for five cycles: exactly one pulse at T+1+WC.
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        pulses = 0;
        pos = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_i);
            if (mem_ready_o) begin
                pulses++;
                pos = i;
            end
            if (i == 5) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        checkOutput("held_pulse_count", pulses, 1);
        checkOutput("held_pulse_pos", pos, 1 + WC);

        // Reset in the second wait cycle aborts a write.
        doAccess("wr20_old", 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, r, e);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_no_ready", {31'd0, mem_ready_o}, 32'd0);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        waitReady("rd20_after_reset", r, e);
        checkOutput("rd20_old_value", r, 32'hCAFEF00D);
        checkOutput("model_word8", mmem[8], 32'hCAFEF00D);

        // Upper address bits: aliasing, or error when checking is enabled.
        doAccess("pre0", 1'b1, 4'hF, 32'h0, 32'h0BADC0DE, r, e);
        doAccess("pre4", 1'b1, 4'hF, 32'h4, 32'h11111111, r, e);
        doAccess("wr1000", 1'b1, 4'hF, 32'h00001000, 32'hFFFFFFFF, r, e);
        checkOutput("wr1000_err", {31'd0, e}, {31'd0, ERR_EN});
        doAccess("wr1004", 1'b1, 4'hF, 32'h00001004, 32'hA5A5A5A5, r, e);
        doAccess("rd0", 1'b0, 4'hF, 32'h0, 32'd0, r, e);
        checkOutput("rd0_data", r, ERR_EN ? 32'h0BADC0DE : 32'hFFFFFFFF);
        doAccess("rd4", 1'b0, 4'hF, 32'h4, 32'd0, r, e);
        checkOutput("rd4_data", r, ERR_EN ? 32'h11111111 : 32'hA5A5A5A5);
        doAccess("rd1004", 1'b0, 4'hF, 32'h00001004, 32'd0, r, e);
        checkOutput("rd1004_data", r, ERR_EN ? 32'h0 : 32'hA5A5A5A5);
        checkOutput("rd1004_err", {31'd0, e}, {31'd0, ERR_EN});

        // Give every word the random phase can address a known value.
        for (int i = 0; i < 16; i++) begin
            doAccess("preload", 1'b1, 4'hF, 32'(i * 4), $urandom, r, e);
        end

        // Random traffic: inputs change every cycle, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 39) != 0);
            a = $urandom;
            a[AW+1:6] = '0;
            if ($urandom_range(0, 3) != 0) a[31:AW+2] = '0;
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                          4'($urandom), a, $urandom);
        end

        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (8) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
